// File: rtl/conv_layer_output_cache_pkg.sv
// global_define: shared word width, drain FSM encodings and FLOAT32 constants
// for the convolution output cache.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package global_define;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [`DATA_WIDTH-1:0] FLOAT32_ZERO = '0;

endpackage

// File: rtl/conv_layer_output_cache_word_sel.sv
// conv_output_word_sel: picks word[col] of a row (word 0 in the MSB slice).
// Define CONV_OUTPUT_RELU_EN to clamp negative words to FLOAT32 zero.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module conv_output_word_sel
    import global_define::*;
#(
    parameter int ARRAY_SIZE = 6,
    parameter int CW         = 3
) (
    input  logic [ARRAY_SIZE*`DATA_WIDTH-1:0] row,
    input  logic [CW-1:0]                     col,
    output logic [`DATA_WIDTH-1:0]            word
);

    logic [`DATA_WIDTH-1:0] sel;

    assign sel = row[(ARRAY_SIZE-1-int'(col))*`DATA_WIDTH +: `DATA_WIDTH];

`ifdef CONV_OUTPUT_RELU_EN
    assign word = sel[`DATA_WIDTH-1] ? FLOAT32_ZERO : sel;
`else
    assign word = sel;
`endif

endmodule

// File: rtl/conv_layer_output_cache.sv
// conv_layer_output_cache: ping-pong row cache that serialises result rows into
// row-major addressed words. Optional ReLU on output via CONV_OUTPUT_RELU_EN.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module conv_layer_output_cache
    import global_define::*;
#(
    parameter int ARRAY_SIZE = 6,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              frame_start,
    input  logic                              row_valid,
    input  logic [ARRAY_SIZE*`DATA_WIDTH-1:0] row_data_bus,
    output logic                              row_ready,
    input  logic                              out_ready,
    output logic [`DATA_WIDTH-1:0]            data_out,
    output logic                              data_out_valid,
    output logic [ADDR_WIDTH-1:0]             wr_addr,
    output logic                              frame_done
);

    localparam int CW = ARRAY_SIZE > 1 ? $clog2(ARRAY_SIZE) : 1;
    localparam int RW = ARRAY_SIZE*`DATA_WIDTH;
    localparam logic [CW-1:0] LAST_COL = CW'(ARRAY_SIZE-1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(ARRAY_SIZE*ARRAY_SIZE-1);

    state_t        state;
    logic [RW-1:0] bank [2];
    logic [1:0]    full;
    logic          wr_sel;
    logic          rd_sel;
    logic [CW-1:0] col;
    logic          capture;
    logic          accept;
    logic          row_end;

    assign row_ready      = !full[wr_sel];
    assign data_out_valid = state == ST_DRAIN;
    assign frame_done     = state == ST_DONE;
    assign capture        = row_valid && row_ready;
    assign accept         = data_out_valid && out_ready;
    assign row_end        = accept && col == LAST_COL;

    // Capture and free always target different banks, so both may update full in one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            bank[0] <= '0;
            bank[1] <= '0;
            full    <= '0;
            wr_sel  <= 1'b0;
            rd_sel  <= 1'b0;
            col     <= '0;
            wr_addr <= '0;
        end else if (frame_start) begin
            state   <= ST_IDLE;
            full    <= '0;
            wr_sel  <= 1'b0;
            rd_sel  <= 1'b0;
            col     <= '0;
            wr_addr <= '0;
        end else begin
            if (capture) begin
                bank[wr_sel] <= row_data_bus;
                full[wr_sel] <= 1'b1;
                wr_sel       <= !wr_sel;
            end
            if (accept) begin
                col     <= row_end ? '0 : col + 1'b1;
                wr_addr <= wr_addr == LAST_ADDR ? '0 : wr_addr + 1'b1;
            end
            if (row_end) begin
                full[rd_sel] <= 1'b0;
                rd_sel       <= !rd_sel;
            end
            case (state)
                ST_IDLE:  if (full[rd_sel]) state <= ST_DRAIN;
                ST_DRAIN: if (row_end) state <= wr_addr == LAST_ADDR ? ST_DONE :
                                                full[!rd_sel] ? ST_DRAIN : ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    conv_output_word_sel #(
        .ARRAY_SIZE(ARRAY_SIZE),
        .CW        (CW)
    ) u_word_sel (
        .row (bank[rd_sel]),
        .col (col),
        .word(data_out)
    );

endmodule

// File: tb/tb_conv_layer_output_cache.sv
// tb_conv_layer_output_cache: scoreboard bench for the output cache.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module tb_conv_layer_output_cache;

    localparam int AS = 6;
    localparam int AW = 8;
    localparam int DW = `DATA_WIDTH;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            frame_start = 1'b0;
    logic            row_valid = 1'b0;
    logic            out_ready = 1'b0;
    logic [AS*DW-1:0] row_data_bus = '0;
    logic            row_ready;
    logic            data_out_valid;
    logic            frame_done;
    logic [DW-1:0]   data_out;
    logic [AW-1:0]   wr_addr;

    conv_layer_output_cache #(.ARRAY_SIZE(AS), .ADDR_WIDTH(AW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .frame_start   (frame_start),
        .row_valid     (row_valid),
        .row_data_bus  (row_data_bus),
        .row_ready     (row_ready),
        .out_ready     (out_ready),
        .data_out      (data_out),
        .data_out_valid(data_out_valid),
        .wr_addr       (wr_addr),
        .frame_done    (frame_done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int passed = 0;
    int n_pop = 0;
    int fd_cycles = 0;
    logic [AW-1:0] last_addr = '0;
    logic [AW-1:0] fd_addr = '0;
    logic [AW-1:0] exp_addr = '0;
    logic [AW+DW-1:0] sb [$];
    logic [AW+DW-1:0] mon_e;
    logic [DW-1:0] fl [AS] = '{32'h3F800000, 32'h40000000, 32'h40400000,
                               32'h40800000, 32'h40A00000, 32'h40C00000};
    logic [DW-1:0] neg [AS] = '{32'h3F800000, 32'hBF800000, 32'h00000000,
                                32'h80000000, 32'h7F7FFFFF, 32'hFFFFFFFF};

    function automatic logic [DW-1:0] relu(input logic [DW-1:0] w);
`ifdef CONV_OUTPUT_RELU_EN
        return w[DW-1] ? '0 : w;
`else
        return w;
`endif
    endfunction

    function automatic logic [AS*DW-1:0] pack(input logic [DW-1:0] w [AS]);
        logic [AS*DW-1:0] p;
        for (int i = 0; i < AS; i++) p[(AS-1-i)*DW +: DW] = w[i];
        return p;
    endfunction

    function automatic logic [AS*DW-1:0] rnd_row();
        logic [AS*DW-1:0] p;
        for (int i = 0; i < AS; i++) p[i*DW +: DW] = $urandom();
        return p;
    endfunction

    // Monitor: every accepted word is popped from the scoreboard and compared.
    always @(negedge clk) begin
        if (frame_done) begin
            fd_cycles++;
            fd_addr = last_addr;
        end
        if (data_out_valid && out_ready) begin
            total++;
            if (sb.size() == 0) begin
                $display("FAIL unexpected_word: got data %h addr %0d, expected no word", data_out, wr_addr);
            end else begin
                mon_e = sb.pop_front();
                if (data_out !== mon_e[DW-1:0])
                    $display("FAIL word_data: got %h expected %h", data_out, mon_e[DW-1:0]);
                else passed++;
                total++;
                if (wr_addr !== mon_e[AW+DW-1:DW])
                    $display("FAIL word_addr: got %0d expected %0d", wr_addr, mon_e[AW+DW-1:DW]);
                else passed++;
            end
            last_addr = wr_addr;
            n_pop++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_frame_start();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        sb.delete();
        exp_addr = '0;
        fd_cycles = 0;
    endtask

    task automatic send_row(input logic [AS*DW-1:0] bus);
        int n = 0;
        while (!row_ready && n < 300) begin
            tick();
            n++;
        end
        if (!row_ready) begin
            total++;
            $display("FAIL send_row_timeout: row_ready=%b expected 1", row_ready);
        end else begin
            row_valid = 1'b1;
            row_data_bus = bus;
            tick();
            row_valid = 1'b0;
            for (int i = 0; i < AS; i++) begin
                sb.push_back({exp_addr, relu(bus[(AS-1-i)*DW +: DW])});
                exp_addr = exp_addr == AW'(AS*AS-1) ? '0 : exp_addr + 1'b1;
            end
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((sb.size() != 0 || data_out_valid) && n < 500) begin
            tick();
            n++;
        end
        total++;
        if (sb.size() != 0 || data_out_valid)
            $display("FAIL drain: %0d words still pending, valid=%b expected 0 and 0", sb.size(), data_out_valid);
        else passed++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        out_ready = 1'b1;
        row_valid = 1'b1;
        row_data_bus = rnd_row();
        repeat (3) tick();
        total += 5;
        if (row_ready !== 1'b1) $display("FAIL reset_row_ready: got %b expected 1", row_ready); else passed++;
        if (data_out_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", data_out_valid); else passed++;
        if (data_out !== '0) $display("FAIL reset_data: got %h expected 0", data_out); else passed++;
        if (wr_addr !== '0) $display("FAIL reset_addr: got %0d expected 0", wr_addr); else passed++;
        if (frame_done !== 1'b0) $display("FAIL reset_frame_done: got %b expected 0", frame_done); else passed++;
        row_valid = 1'b0;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_row();
        out_ready = 1'b1;
        pulse_frame_start();
        send_row(pack(fl));
        total++;
        if (data_out_valid !== 1'b0) $display("FAIL latency_capture_cycle: valid got %b expected 0", data_out_valid); else passed++;
        tick();
        total++;
        if ({data_out_valid, data_out, wr_addr} !== {1'b1, 32'h3F800000, 8'd0})
            $display("FAIL latency_word0: got valid %b data %h addr %0d expected 1 3f800000 0", data_out_valid, data_out, wr_addr);
        else passed++;
        wait_drain();
    endtask

    task automatic test_backpressure();
        logic [AS*DW-1:0] a = rnd_row();
        int p0;
        int n = 0;
        out_ready = 1'b0;
        pulse_frame_start();
        send_row(a);
        send_row(rnd_row());
        total++;
        if (row_ready !== 1'b0) $display("FAIL third_row_blocked: row_ready got %b expected 0", row_ready); else passed++;
        row_valid = 1'b1;
        row_data_bus = rnd_row();
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if ({data_out_valid, data_out, wr_addr, row_ready} !== {1'b1, relu(a[AS*DW-1 -: DW]), 8'd0, 1'b0})
                $display("FAIL hold_stable: got valid %b data %h addr %0d ready %b expected 1 %h 0 0",
                         data_out_valid, data_out, wr_addr, row_ready, relu(a[AS*DW-1 -: DW]));
            else passed++;
        end
        row_valid = 1'b0;
        out_ready = 1'b1;
        p0 = n_pop;
        while (!row_ready && n < 50) begin
            tick();
            n++;
        end
        total++;
        if (n_pop - p0 != AS) $display("FAIL drained_before_third: got %0d words expected %0d", n_pop - p0, AS); else passed++;
        send_row(rnd_row());
        wait_drain();
    endtask

    task automatic test_frame_wrap();
        out_ready = 1'b1;
        pulse_frame_start();
        for (int r = 0; r <= AS; r++) send_row(rnd_row());
        wait_drain();
        total += 2;
        if (fd_cycles != 1) $display("FAIL frame_done_cycles: got %0d expected 1", fd_cycles); else passed++;
        if (fd_addr !== AW'(AS*AS-1)) $display("FAIL frame_done_after: last addr got %0d expected %0d", fd_addr, AS*AS-1); else passed++;
    endtask

    task automatic test_relu();
        int n = 0;
        out_ready = 1'b1;
        pulse_frame_start();
        send_row(pack(neg));
        while (!(data_out_valid && wr_addr == 8'd1) && n < 50) begin
            tick();
            n++;
        end
        total++;
`ifdef CONV_OUTPUT_RELU_EN
        if (data_out !== 32'h0) $display("FAIL relu_neg_one: got %h expected 00000000", data_out); else passed++;
`else
        if (data_out !== 32'hBF800000) $display("FAIL relu_neg_one: got %h expected bf800000", data_out); else passed++;
`endif
        wait_drain();
    endtask

    task automatic test_reset_midframe();
        int p0;
        int n = 0;
        out_ready = 1'b1;
        pulse_frame_start();
        send_row(rnd_row());
        send_row(rnd_row());
        while (!(data_out_valid && wr_addr == 8'd9) && n < 100) begin
            tick();
            n++;
        end
        rst_n = 1'b0;
        #1;
        total += 4;
        if (data_out_valid !== 1'b0) $display("FAIL midreset_valid: got %b expected 0", data_out_valid); else passed++;
        if (row_ready !== 1'b1) $display("FAIL midreset_row_ready: got %b expected 1", row_ready); else passed++;
        if (data_out !== '0) $display("FAIL midreset_data: got %h expected 0", data_out); else passed++;
        if (wr_addr !== '0) $display("FAIL midreset_addr: got %0d expected 0", wr_addr); else passed++;
        sb.delete();
        exp_addr = '0;
        tick();
        tick();
        rst_n = 1'b1;
        p0 = n_pop;
        repeat (5) tick();
        total++;
        if (n_pop != p0 || data_out_valid !== 1'b0)
            $display("FAIL midreset_discard: got %0d words valid %b expected 0 words valid 0", n_pop - p0, data_out_valid);
        else passed++;
    endtask

    task automatic test_frame_start_collision();
        out_ready = 1'b1;
        frame_start = 1'b1;
        row_valid = 1'b1;
        row_data_bus = rnd_row();
        tick();
        frame_start = 1'b0;
        row_valid = 1'b0;
        sb.delete();
        exp_addr = '0;
        total++;
        if (row_ready !== 1'b1) $display("FAIL collision_ready: got %b expected 1", row_ready); else passed++;
        repeat (3) tick();
        total++;
        if (data_out_valid !== 1'b0) $display("FAIL collision_no_output: valid got %b expected 0", data_out_valid); else passed++;
    endtask

    initial begin
        test_reset();
        test_single_row();
        test_backpressure();
        test_frame_wrap();
        test_relu();
        test_reset_midframe();
        test_frame_start_collision();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation still running, expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/conv_layer_output_cache.md
CONV_LAYER_OUTPUT_CACHE -- requirements
Module: conv_layer_output_cache

Interface
REQ-001 SHALL have parameter ARRAY_SIZE, default 6; number of result words per row and rows per frame.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8; width of the write-address output.
REQ-003 SHALL use the global `DATA_WIDTH macro (32) for every word width.
REQ-004 clk  input  1  clock; all state changes on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 frame_start  input  1  one-cycle pulse; clears all state for a new output frame.
REQ-007 row_valid  input  1  row_data_bus holds one complete result row.
REQ-008 row_data_bus  input  ARRAY_SIZE*`DATA_WIDTH  result row; word 0 in the MSB slice, word ARRAY_SIZE-1 in the LSB slice.
REQ-009 row_ready  output  1  cache can accept a row this cycle.
REQ-010 out_ready  input  1  downstream memory accepts data_out this cycle.
REQ-011 data_out  output  `DATA_WIDTH  current serial result word.
REQ-012 data_out_valid  output  1  data_out and wr_addr are valid.
REQ-013 wr_addr  output  ADDR_WIDTH  destination address of data_out, row-major within the frame.
REQ-014 frame_done  output  1  one-cycle pulse after the last word of a frame is accepted.

Function
REQ-015 SHALL hold two row banks (ping-pong), each ARRAY_SIZE words, with a full flag per bank, a write-bank select, and a read-bank select.
REQ-016 row_ready SHALL be 1 exactly when the bank under the write select is not full.
REQ-017 On row_valid & row_ready, SHALL store row_data_bus into the write bank, set its full flag, and toggle the write select. row_valid with row_ready=0 SHALL be ignored and SHALL leave all state unchanged.
REQ-018 SHALL run the state machine ST_IDLE -> ST_DRAIN when the read bank is full. ST_DRAIN -> ST_IDLE when the last word of a row is accepted and the other bank is empty; otherwise it SHALL stay in ST_DRAIN. Acceptance of word ARRAY_SIZE*ARRAY_SIZE-1 SHALL go to ST_DONE, and ST_DONE -> ST_IDLE after one cycle.
REQ-019 data_out_valid SHALL be 1 only in ST_DRAIN. data_out SHALL be word[col] of the read bank, where col is a column counter 0..ARRAY_SIZE-1.
REQ-020 A word SHALL be accepted on data_out_valid & out_ready; each acceptance increments col and wr_addr.
REQ-021 Acceptance at col=ARRAY_SIZE-1 SHALL clear the read bank's full flag, reset col to 0, and toggle the read select.
REQ-022 Latency: a row captured at edge N SHALL present word 0 with data_out_valid=1 in cycle N+1, provided the drain path is idle.
REQ-023 When out_ready=0, data_out, wr_addr, and data_out_valid SHALL be held stable.
REQ-024 Capture into one bank and freeing of the other bank in the same cycle SHALL both take effect.
REQ-025 wr_addr SHALL wrap from ARRAY_SIZE*ARRAY_SIZE-1 to 0 on acceptance; frame_done SHALL be 1 only in ST_DONE.
REQ-026 frame_start SHALL clear both full flags, both selects, col, and wr_addr, and SHALL force ST_IDLE. It SHALL take priority over a same-cycle row capture or word acceptance; that row is dropped.

Reset
REQ-027 While rst_n=0, SHALL hold: state ST_IDLE, banks zero, flags, selects, col, and wr_addr zero.
REQ-028 While rst_n=0, SHALL drive outputs: row_ready=1, data_out_valid=0, data_out=0, wr_addr=0, frame_done=0.
REQ-029 Reset asserted mid-frame SHALL discard all buffered rows without emitting further words.

Configuration
REQ-030 With CONV_OUTPUT_RELU_EN defined, data_out SHALL be 32'h0 whenever the selected word's sign bit is 1, and the word unchanged otherwise.
REQ-031 Without CONV_OUTPUT_RELU_EN, data_out SHALL be the stored word unchanged. Timing and handshake SHALL be identical in both builds.

Structure
REQ-032 State encodings ST_IDLE/ST_DRAIN/ST_DONE and the FLOAT32 zero constant SHALL live in the shared global_define package beside `DATA_WIDTH.
REQ-033 SHALL be one module; the word-select-plus-ReLU mux MAY be a sub-module named conv_output_word_sel.

Verification
REQ-034 After frame_start, one row {1.0,2.0,...,6.0} (32'h3F800000...) with out_ready=1 -> six words in order, wr_addr 0..5, valid one cycle after capture.
REQ-035 Three rows back-to-back with out_ready=0 -> first two captured, row_ready=0 on third. Raise out_ready -> third row accepted after 6 words drained.
REQ-036 36 words accepted continuously -> frame_done=1 for exactly one cycle after wr_addr=35 is accepted; next word gets wr_addr=0.
REQ-037 Word 32'hBF800000 (-1.0) -> data_out=0 with CONV_OUTPUT_RELU_EN defined, 32'hBF800000 without it.
REQ-038 rst_n low during word 3 of row 2 -> data_out_valid=0 immediately, row_ready=1. frame_start coincident with row_valid -> row not captured.
